// File: rtl/mem_request_queue_pkg.sv
// Shared widths, FSM state encoding and debug view for the memory request queue.
package InstructionStruct;

  localparam int DWIDTH    = 32;
  localparam int CPUAWIDTH = 32;
  localparam int AWIDTH    = CPUAWIDTH - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } mq_state_e;

  // Pointers and count are zero-extended to 8 bits so the view is DEPTH-independent.
  typedef struct packed {
    mq_state_e  state;
    logic       mem_oe;
    logic [7:0] count;
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;
  } mq_dbg_t;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_request_queue_if.sv
// Pipeline-side request/response bundle of the memory request queue.
// A request transfers on a rising edge where req_valid && req_ready; the master holds
// req_rw/req_addr/req_wdata stable while req_valid is high and req_ready never depends on req_valid.
interface mem_request_queue_if;
  import InstructionStruct::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_rw;
  logic [CPUAWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0]    req_wdata;
  logic                 rsp_valid;
  logic [DWIDTH-1:0]    rsp_rdata;
  logic                 err_misalign;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, err_misalign
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, err_misalign
  );

endinterface

// File: rtl/mem_request_queue_fifo.sv
// Request FIFO: DEPTH entries (power of two), pointers wrap naturally modulo DEPTH.
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [PW-1:0]    wr_ptr,
  output logic [PW-1:0]    rd_ptr
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign wr_ptr   = wr_ptr_q;
  assign rd_ptr   = rd_ptr_q;

endmodule

// File: rtl/mem_request_queue.sv
// Queues pipeline memory requests and replays them one at a time on a shared tristate
// memory bus: IDLE -> ISSUE (strobe) -> WAIT (RD_LAT cycles) -> DONE (turnaround).
module mem_request_queue
  import InstructionStruct::*;
#(
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_request_queue_if.slave   req_if,
  output logic                 mem_valid,
  output logic                 mem_rw,
  output logic [CPUAWIDTH-1:0] mem_addr,
  inout  wire  [DWIDTH-1:0]    mem_data,
  output logic                 busy,
  output mq_dbg_t              dbg
);

  localparam int EW   = 1 + CPUAWIDTH + DWIDTH;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int CNTW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

  logic          fifo_full, fifo_empty;
  logic          push, pop, accept;
  logic [EW-1:0] push_entry, pop_entry;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] fifo_wr_ptr, fifo_rd_ptr;

  mq_state_e             state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_rw_q, mem_rw_d;
  logic [CPUAWIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0]     wdata_q, wdata_d;
  logic                  oe_q, oe_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;

  // Misaligned requests complete the handshake but are dropped instead of enqueued.
  assign accept     = req_if.req_valid && req_if.req_ready;
  assign push       = accept && is_aligned(req_if.req_addr[1:0]);
  assign err_d      = accept && !is_aligned(req_if.req_addr[1:0]);
  assign push_entry = {req_if.req_rw, req_if.req_addr, req_if.req_wdata};

  req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .wr_ptr    (fifo_wr_ptr),
    .rd_ptr    (fifo_rd_ptr)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_valid_d = 1'b0;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    wdata_d     = wdata_q;
    oe_d        = oe_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          state_d     = ISSUE;
          mem_valid_d = 1'b1;
          {mem_rw_d, mem_addr_d, wdata_d} = pop_entry;
          oe_d        = !pop_entry[EW-1];
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CNTW'(RD_LAT - 1);
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          oe_d    = 1'b0;
          if (mem_rw_q) begin
            rsp_valid_d = 1'b1;
            rdata_d     = mem_data;
          end
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b1;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      wdata_q     <= wdata_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Only writes ever drive the bus; reads leave it to the memory.
  assign mem_data = oe_q ? wdata_q : 'z;

  assign mem_valid           = mem_valid_q;
  assign mem_rw              = mem_rw_q;
  assign mem_addr            = mem_addr_q;
  assign req_if.req_ready    = !fifo_full;
  assign req_if.rsp_valid    = rsp_valid_q;
  assign req_if.rsp_rdata    = rdata_q;
  assign req_if.err_misalign = err_q;
  assign busy                = !fifo_empty || (state_q != IDLE);

  always_comb begin
    dbg        = '0;
    dbg.state  = state_q;
    dbg.mem_oe = oe_q;
    dbg.count  = 8'(fifo_count);
    dbg.wr_ptr = 8'(fifo_wr_ptr);
    dbg.rd_ptr = 8'(fifo_rd_ptr);
  end

endmodule

// File: tb/tb_mem_request_queue.sv
// Directed bench for mem_request_queue with a small tristate memory model on mem_data.
module tb_mem_request_queue;
  import InstructionStruct::*;

  localparam int RD_LAT = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 mem_valid;
  logic                 mem_rw;
  logic [CPUAWIDTH-1:0] mem_addr;
  wire  [DWIDTH-1:0]    mem_data;
  logic                 busy;
  mq_dbg_t              dbg;

  mem_request_queue_if bus ();

  mem_request_queue #(.DEPTH(4), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_if    (bus),
    .mem_valid (mem_valid),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy),
    .dbg       (dbg)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_mv     = 0;
  int n_rsp    = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory model: samples commands at the edge, drives read data for RD_LAT edges.
  logic [31:0] mem_arr [16];
  logic        tb_drv_en = 1'b0;
  logic [31:0] tb_drv_val = '0;
  int          drv_cnt = 0;

  assign mem_data = tb_drv_en ? tb_drv_val : 'z;

  always @(posedge clk) begin : mem_model
    logic        mv, mrw;
    logic [31:0] ma, md;
    mv  = mem_valid;
    mrw = mem_rw;
    ma  = mem_addr;
    md  = mem_data;
    #1;
    if (!reset) begin
      tb_drv_en = 1'b0;
      drv_cnt   = 0;
    end else begin
      if (tb_drv_en) begin
        drv_cnt--;
        if (drv_cnt == 0) tb_drv_en = 1'b0;
      end
      if (mv) begin
        if (!mrw) mem_arr[ma[5:2]] = md;
        else begin
          tb_drv_val = mem_arr[ma[5:2]];
          drv_cnt    = RD_LAT;
          tb_drv_en  = 1'b1;
        end
      end
    end
  end

  always @(negedge reset) tb_drv_en = 1'b0;

  // Scoreboard / monitor
  always @(negedge clk) begin
    if (reset) begin
      if (mem_valid) n_mv++;
      if (bus.err_misalign) n_err++;
      if (bus.rsp_valid) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual=%h required=no_response", bus.rsp_rdata);
        end else begin
          check("rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
        end
      end
      check("bus_single_driver", 32'(dbg.mem_oe && tb_drv_en), 32'd0);
    end
  end

  task automatic send(input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
    int k = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (!bus.req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!bus.req_ready) begin
      failures++;
      $display("FAIL send_timeout actual=ready0 required=ready1 addr=%h", addr);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    @(negedge clk);
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
    check({tag, "_mem_rw"}, 32'(mem_rw), 32'd1);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_oe"}, 32'(dbg.mem_oe), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    check({tag, "_err"}, 32'(bus.err_misalign), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_state"}, 32'(dbg.state), 32'(IDLE));
    check({tag, "_count"}, 32'(dbg.count), 32'd0);
    check({tag, "_wr_ptr"}, 32'(dbg.wr_ptr), 32'd0);
    check({tag, "_rd_ptr"}, 32'(dbg.rd_ptr), 32'd0);
  endtask

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_mv;
    int          exp_rsp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int mv0, rsp0, err0;
    logic [31:0] bp_addr [5];
    logic [31:0] bp_data [5];
    logic        bp_ready [4];
    mq_state_e   lat_state [5];
    logic        lat_mv [5];
    logic        lat_oe [5];
    logic        lat_rsp [5];
    int          k;

    for (int i = 0; i < 16; i++) mem_arr[i] = 32'hC0DE_0000 + 32'(i);
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    vecs[0] = '{1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1, 0, 32'h0};
    vecs[1] = '{1'b1, 32'h10, 32'h0,        1'b0, 1, 1, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 32'h14, 32'h12345678, 1'b0, 1, 0, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 32'h12, 32'h0,        1'b1, 0, 0, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 32'h14, 32'h0,        1'b0, 1, 1, 32'h12345678};
    vecs[5] = '{1'b0, 32'h20, 32'hA5A5A5A5, 1'b0, 1, 0, 32'h12345678};
    vecs[6] = '{1'b1, 32'h20, 32'h0,        1'b0, 1, 1, 32'hA5A5A5A5};
    vecs[7] = '{1'b0, 32'h13, 32'h11111111, 1'b1, 0, 0, 32'hA5A5A5A5};
    vecs[8] = '{1'b1, 32'h3C, 32'h0,        1'b0, 1, 1, 32'hC0DE000F};
    vecs[9] = '{1'b1, 32'h01, 32'h0,        1'b1, 0, 0, 32'hC0DE000F};

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;

    // Table-driven single transactions
    for (int i = 0; i < 10; i++) begin
      mv0  = n_mv;
      rsp0 = n_rsp;
      err0 = n_err;
      if (vecs[i].exp_rsp != 0) exp_q.push_back(vecs[i].exp_rdata);
      send(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      check($sformatf("v%0d_err_pulse", i), 32'(bus.err_misalign), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_ready_kept", i), 32'(bus.req_ready), 32'd1);
      wait_idle(50);
      check($sformatf("v%0d_mem_valid_cnt", i), 32'(n_mv - mv0), 32'(vecs[i].exp_mv));
      check($sformatf("v%0d_rsp_cnt", i), 32'(n_rsp - rsp0), 32'(vecs[i].exp_rsp));
      check($sformatf("v%0d_err_cnt", i), 32'(n_err - err0), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_rdata_hold", i), bus.rsp_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_count", i), 32'(dbg.count), 32'd0);
    end

    // Cycle-by-cycle latency from acceptance: read then write
    lat_state = '{IDLE, ISSUE, WAIT, WAIT, DONE};
    lat_mv    = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int t = 0; t < 2; t++) begin
      logic is_rd;
      is_rd = (t == 0);
      if (is_rd) begin
        lat_oe  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        lat_rsp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_q.push_back(32'hC0DE0007);
      end else begin
        lat_oe  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        lat_rsp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      end
      send(is_rd, 32'h1C, 32'h55AA33CC);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        check($sformatf("lat%0d_c%0d_state", t, c), 32'(dbg.state), 32'(lat_state[c]));
        check($sformatf("lat%0d_c%0d_mem_valid", t, c), 32'(mem_valid), 32'(lat_mv[c]));
        check($sformatf("lat%0d_c%0d_mem_oe", t, c), 32'(dbg.mem_oe), 32'(lat_oe[c]));
        check($sformatf("lat%0d_c%0d_rsp_valid", t, c), 32'(bus.rsp_valid), 32'(lat_rsp[c]));
        if (c > 0) begin
          check($sformatf("lat%0d_c%0d_mem_addr", t, c), mem_addr, 32'h1C);
          check($sformatf("lat%0d_c%0d_mem_rw", t, c), 32'(mem_rw), 32'(is_rd));
        end
        if (lat_oe[c]) check($sformatf("lat%0d_c%0d_mem_data", t, c), mem_data, 32'h55AA33CC);
      end
      @(negedge clk);
      check($sformatf("lat%0d_end_state", t), 32'(dbg.state), 32'(IDLE));
      check($sformatf("lat%0d_end_busy", t), 32'(busy), 32'd0);
    end

    // Backpressure: write occupies the FSM, then five back-to-back reads
    bp_addr  = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h18};
    bp_data  = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003, 32'hC0DE0006};
    bp_ready = '{1'b1, 1'b1, 1'b1, 1'b0};
    rsp0 = n_rsp;
    send(1'b0, 32'h24, 32'h0BADF00D);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(bp_data[i]);
      send(1'b1, bp_addr[i], 32'h0);
      if (i < 4) check($sformatf("bp_ready_after_%0d", i + 1), 32'(bus.req_ready), 32'(bp_ready[i]));
    end
    wait_idle(200);
    check("bp_rsp_cnt", 32'(n_rsp - rsp0), 32'd5);
    check("bp_queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(32'h0BADF00D);
    send(1'b1, 32'h24, 32'h0);
    wait_idle(50);

    // Simultaneous push and pop at count=2 with write pointer wrapping 3->0
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(32'hC0DE000A);
    send(1'b1, 32'h28, 32'h0);
    exp_q.push_back(32'hC0DE000B);
    send(1'b1, 32'h2C, 32'h0);
    exp_q.push_back(32'hC0DE000C);
    send(1'b1, 32'h30, 32'h0);
    check("wrap_pre_count", 32'(dbg.count), 32'd2);
    check("wrap_pre_wr_ptr", 32'(dbg.wr_ptr), 32'd3);
    check("wrap_pre_rd_ptr", 32'(dbg.rd_ptr), 32'd1);
    k = 0;
    @(negedge clk);
    while (dbg.state != DONE && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("wrap_reach_done", 32'(dbg.state), 32'(DONE));
    @(negedge clk);
    check("wrap_idle_before", 32'(dbg.state), 32'(IDLE));
    check("wrap_count_before", 32'(dbg.count), 32'd2);
    exp_q.push_back(32'hC0DE000D);
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b1;
    bus.req_addr  = 32'h34;
    bus.req_wdata = 32'h0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("wrap_post_count", 32'(dbg.count), 32'd2);
    check("wrap_post_wr_ptr", 32'(dbg.wr_ptr), 32'd0);
    check("wrap_post_rd_ptr", 32'(dbg.rd_ptr), 32'd2);
    check("wrap_post_state", 32'(dbg.state), 32'(ISSUE));
    wait_idle(200);
    check("wrap_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset asserted during WAIT of a read with another read queued
    send(1'b1, 32'h00, 32'h0);
    send(1'b1, 32'h04, 32'h0);
    k = 0;
    @(negedge clk);
    while (dbg.state != WAIT && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("abort_reach_wait", 32'(dbg.state), 32'(WAIT));
    reset = 1'b0;
    #1;
    check_reset_values("abort");
    @(negedge clk);
    reset = 1'b1;
    rsp0 = n_rsp;
    mv0  = n_mv;
    repeat (10) @(negedge clk);
    check("abort_no_rsp", 32'(n_rsp - rsp0), 32'd0);
    check("abort_no_mem_valid", 32'(n_mv - mv0), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
